// File: rtl/sort_merge_acc.sv
// sort_merge_acc: merges sorted sort4 groups over a frame into a global
// bottom-2 (min1 <= min2) and top-2 (max1 >= max2). It also counts groups
// and hands the frame result downstream on a valid/ready handshake.
// Optional macro SORT_MERGE_SIGNED_EN: when defined, all min/max comparisons
// use two's-complement signed data. When undefined, comparisons are unsigned.
module sort_merge_acc #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [DATA_W-1:0] small1,
  input  logic [DATA_W-1:0] small2,
  input  logic [DATA_W-1:0] large1,
  input  logic [DATA_W-1:0] large2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] min1,
  output logic [DATA_W-1:0] min2,
  output logic [DATA_W-1:0] max1,
  output logic [DATA_W-1:0] max2,
  output logic [CNT_W-1:0]  grp_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]        r_state, w_state_nx;
  logic              r_in_ready, r_out_valid;
  logic [DATA_W-1:0] r_min1, r_min2, r_max1, r_max2;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_acc, w_out_hs;
  logic [DATA_W-1:0] w_min1, w_min2, w_max1, w_max2;

  // Single comparison point so the signed/unsigned choice lives in one place
  function automatic logic f_lt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef SORT_MERGE_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] f_min(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return f_lt(a, b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] f_max(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return f_lt(a, b) ? b : a;
  endfunction

  assign w_acc    = in_valid && r_in_ready;
  assign w_out_hs = r_out_valid && out_ready;

  // Bottom-2 of the union of two bottom-2 pairs.
  // The runner-up is the loser of the two leaders or the better of the seconds.
  // Top-2 is the mirror image.
  assign w_min1 = f_min(r_min1, small1);
  assign w_min2 = f_min(f_max(r_min1, small1), f_min(r_min2, small2));
  assign w_max1 = f_max(r_max1, large1);
  assign w_max2 = f_max(f_min(r_max1, large1), f_max(r_max2, large2));

  // Next-state logic for the frame sequencer
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_acc) w_state_nx = in_last ? S_OUT : S_ACC;
      S_ACC:   if (w_acc && in_last) w_state_nx = S_OUT;
      S_OUT:   if (w_out_hs) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State and handshake flags.
  // Both flags are registered off the next state, so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_in_ready  <= (w_state_nx != S_OUT);
      r_out_valid <= (w_state_nx == S_OUT);
    end
  end

  // Result accumulators.
  // The first group of a frame loads directly and later groups merge in.
  // Results persist after the output handshake until the next frame starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_min1 <= '0;
      r_min2 <= '0;
      r_max1 <= '0;
      r_max2 <= '0;
      r_cnt  <= '0;
    end else if (w_acc && r_state == S_IDLE) begin
      r_min1 <= small1;
      r_min2 <= small2;
      r_max1 <= large1;
      r_max2 <= large2;
      r_cnt  <= CNT_W'(1);
    end else if (w_acc && r_state == S_ACC) begin
      r_min1 <= w_min1;
      r_min2 <= w_min2;
      r_max1 <= w_max1;
      r_max2 <= w_max2;
      if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign min1      = r_min1;
  assign min2      = r_min2;
  assign max1      = r_max1;
  assign max2      = r_max2;
  assign grp_cnt   = r_cnt;

endmodule

// File: tb/tb_sort_merge_acc.sv
// Bench for sort_merge_acc: directed frames plus random frames, checked against
// a model that sorts every value of the frame. Honours SORT_MERGE_SIGNED_EN.
module tb_sort_merge_acc;
  localparam int DW = 16;
  localparam int CW = 4;   // small counter so saturation is reachable

`ifdef SORT_MERGE_SIGNED_EN
  typedef logic signed [DW-1:0] d_t;
`else
  typedef logic [DW-1:0] d_t;
`endif
  typedef struct { d_t s1; d_t s2; d_t l1; d_t l2; } grp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] small1, small2, large1, large2;
  logic          out_valid, out_ready;
  logic [DW-1:0] min1, min2, max1, max2;
  logic [CW-1:0] grp_cnt;

  int   n_chk  = 0;
  int   n_fail = 0;
  grp_t plan[$];

  sort_merge_acc #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .small1(small1), .small2(small2), .large1(large1), .large2(large2),
    .out_valid(out_valid), .out_ready(out_ready),
    .min1(min1), .min2(min2), .max1(max1), .max2(max2), .grp_cnt(grp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic add_fix(input d_t s1, input d_t s2, input d_t l1, input d_t l2);
    grp_t g;
    g.s1 = s1; g.s2 = s2; g.l1 = l1; g.l2 = l2;
    plan.push_back(g);
  endtask

  // A legal group is four values sorted in the data's own ordering
  task automatic add_rand(input bit narrow);
    d_t v[$];
    repeat (4) v.push_back(narrow ? d_t'($urandom_range(0, 7)) : d_t'($urandom));
    v.sort();
    add_fix(v[0], v[1], v[3], v[2]);
  endtask

  task automatic junk_inputs();
    small1 = DW'($urandom); small2 = DW'($urandom);
    large1 = DW'($urandom); large2 = DW'($urandom);
  endtask

  // Idle gap cycles carry random in_last with in_valid low, which must be ignored
  task automatic send(input grp_t g, input bit last, input int gap);
    int to;
    repeat (gap) begin
      in_valid = 1'b0; in_last = 1'($urandom_range(0, 1)); junk_inputs(); tick();
    end
    to = 0;
    while (!in_ready && to < 50) begin tick(); to++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_last = last;
    small1 = g.s1; small2 = g.s2; large1 = g.l1; large2 = g.l2;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Send the plan as one frame, then check the result, backpressure and handshake
  task automatic play(input int max_gap, input int bp);
    d_t            vals[$];
    logic [DW-1:0] e_min1, e_min2, e_max1, e_max2;
    logic [CW-1:0] e_cnt;
    int            n;
    n = plan.size();
    foreach (plan[i]) begin
      vals.push_back(plan[i].s1); vals.push_back(plan[i].s2);
      vals.push_back(plan[i].l1); vals.push_back(plan[i].l2);
      send(plan[i], i == n - 1, $urandom_range(0, max_gap));
    end
    vals.sort();
    e_min1 = vals[0];
    e_min2 = vals[1];
    e_max1 = vals[vals.size() - 1];
    e_max2 = vals[vals.size() - 2];
    e_cnt  = (n > 15) ? CW'(15) : CW'(n);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("in_ready_out", 32'(in_ready), 32'd0);
    chk("min1", 32'(min1), 32'(e_min1));
    chk("min2", 32'(min2), 32'(e_min2));
    chk("max1", 32'(max1), 32'(e_max1));
    chk("max2", 32'(max2), 32'(e_max2));
    chk("grp_cnt", 32'(grp_cnt), 32'(e_cnt));
    repeat (bp) begin
      in_valid = 1'b1; in_last = 1'b1; junk_inputs(); out_ready = 1'b0;
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_min1", 32'(min1), 32'(e_min1));
      chk("bp_max2", 32'(max2), 32'(e_max2));
      chk("bp_cnt", 32'(grp_cnt), 32'(e_cnt));
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_valid", 32'(out_valid), 32'd0);
    chk("hs_in_ready", 32'(in_ready), 32'd1);
    chk("hs_hold_max1", 32'(max1), 32'(e_max1));
    plan.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    small1 = '0; small2 = '0; large1 = '0; large2 = '0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_min1", 32'(min1), 32'd0);
    chk("rst_max1", 32'(max1), 32'd0);
    chk("rst_cnt", 32'(grp_cnt), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single-group frame
    add_fix(d_t'(0), d_t'(1), d_t'(70), d_t'(54));
    play(0, 0);
    // Two groups, then three cycles of backpressure with in_valid held high
    add_fix(d_t'(0), d_t'(1), d_t'(70), d_t'(54));
    add_fix(d_t'(3), d_t'(5), d_t'(99), d_t'(60));
    play(0, 3);
    // All-equal duplicates with idle gaps inside the frame
    add_fix(d_t'(7), d_t'(7), d_t'(7), d_t'(7));
    add_fix(d_t'(7), d_t'(7), d_t'(7), d_t'(7));
    play(3, 1);

    // Reset in the middle of a frame discards it
    add_rand(1'b0); add_rand(1'b0);
    send(plan[0], 1'b0, 0);
    send(plan[1], 1'b0, 1);
    plan.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cnt", 32'(grp_cnt), 32'd0);
    chk("mid_rst_min1", 32'(min1), 32'd0);
    chk("mid_rst_min2", 32'(min2), 32'd0);
    chk("mid_rst_max1", 32'(max1), 32'd0);
    chk("mid_rst_max2", 32'(max2), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    add_fix(d_t'(10), d_t'(11), d_t'(13), d_t'(12));
    play(0, 0);

    // Sign-sensitive frame: same bit patterns order differently per mode
`ifdef SORT_MERGE_SIGNED_EN
    add_fix(d_t'(16'hFFFF), d_t'(16'h0000), d_t'(16'h0003), d_t'(16'h0002));
    play(0, 0);
    chk("sgn_min1", 32'(min1), 32'h0000FFFF);
    chk("sgn_max1", 32'(max1), 32'h00000003);
`else
    add_fix(d_t'(16'h0000), d_t'(16'h0002), d_t'(16'hFFFF), d_t'(16'h0003));
    play(0, 0);
    chk("uns_min1", 32'(min1), 32'h00000000);
    chk("uns_max1", 32'(max1), 32'h0000FFFF);
`endif

    // Counter saturation on a long frame
    repeat (20) add_rand(1'b0);
    play(1, 0);

    // Random frames, mixing narrow (duplicate-heavy) and full-range values
    for (int f = 0; f < 25; f++) begin
      int  n;
      bit  nar;
      n   = $urandom_range(1, 6);
      nar = 1'($urandom_range(0, 1));
      repeat (n) add_rand(nar);
      play(2, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_merge_acc.md
Name: sort_merge_acc

Overview:
Downstream consumer of sort4. Each cycle it can accept one sorted group from sort4: the two smallest values (small1 ≤ small2) and the two largest values (large1 ≥ large2). It merges these groups over a frame of output-buffer data into a running global bottom-2 and top-2. When the frame ends, it presents the four results plus a group count to the next stage through a valid/ready handshake.

Parameters:
DATA_W, 16, width of every data value; matches the output-buffer data size used by sort4.
CNT_W, 16, width of the group counter.

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  a sort4 group is present on the input data ports
in_ready  output  1  block can accept a group this cycle
in_last  input  1  qualifies the current group as the final group of the frame
small1  input  DATA_W  smallest value of the group
small2  input  DATA_W  second-smallest value of the group
large1  input  DATA_W  largest value of the group
large2  input  DATA_W  second-largest value of the group
out_valid  output  1  frame result is valid
out_ready  input  1  downstream accepts the result
min1  output  DATA_W  global smallest value of the frame
min2  output  DATA_W  global second-smallest value of the frame
max1  output  DATA_W  global largest value of the frame
max2  output  DATA_W  global second-largest value of the frame
grp_cnt  output  CNT_W  number of groups accepted in the frame

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state = IDLE
  - in_ready = 0 during the reset cycle, then 1
  - out_valid = 0
  - min1, min2, max1, max2 = 0
  - grp_cnt = 0
- Input handshake: a group is accepted when in_valid && in_ready. in_ready is a registered function of state: 1 in IDLE and ACC, 0 in OUT.
- IDLE, on accept:
  - Load min1=small1, min2=small2, max1=large1, max2=large2; grp_cnt=1.
  - Go to ACC, or to OUT if in_last=1.
- ACC, on accept, registered single-cycle merge:
  - min1' = min(min1, small1)
  - min2' = min(max(min1, small1), min(min2, small2))
  - max1' = max(max1, large1)
  - max2' = max(min(max1, large1), max(max2, large2))
  - grp_cnt increments, saturating at all-ones.
  - Go to OUT if in_last=1, else stay in ACC.
- ACC with no accept: hold all state.
- OUT:
  - out_valid=1 in the cycle after the in_last handshake (latency 1).
  - Result outputs are stable while out_valid=1 and out_ready=0.
  - On out_valid && out_ready: go to IDLE, out_valid=0 next cycle; results stay held until the next frame's first accept overwrites them.
- Comparisons are unsigned by default. Equal values are legal; duplicates propagate (e.g. all-equal inputs give min1=min2=max1=max2).
- Input ordering is not checked; misordered groups produce undefined results.
- in_last with in_valid=0 is ignored.
- Reset mid-frame or mid-OUT: returns to the reset values next cycle and discards the partial frame.

Optional Feature:
SORT_MERGE_SIGNED_EN:
- Defined: all min/max comparisons treat data as two's-complement signed DATA_W.
- Undefined: unsigned comparison.
- Ports and timing are identical in both cases.

Test Plan:
1. Single group (small1=0, small2=1, large1=70, large2=54, in_last=1), out_ready=1 -> next cycle out_valid=1 with min1=0, min2=1, max1=70, max2=54, grp_cnt=1; in_ready=0 for that cycle; IDLE the cycle after.
2. Two groups, (0,1,70,54) then (3,5,99,60) with in_last -> min1=0, min2=1, max1=99, max2=70, grp_cnt=2.
3. Backpressure: after case 2, hold out_ready=0 for 3 cycles while in_valid=1 -> outputs unchanged, in_ready=0, no group consumed; out_ready=1 -> handshake, IDLE next cycle.
4. Duplicates: (7,7,7,7) twice, last on the second -> min1=min2=max1=max2=7, grp_cnt=2; interleave in_valid gaps in ACC and confirm state holds.
5. Reset mid-frame: two groups accepted, assert rst for 1 cycle -> out_valid=0, grp_cnt=0, all results 0; a new frame (10,11,13,12, last) -> 10, 11, 13, 12, grp_cnt=1.
6. With SORT_MERGE_SIGNED_EN, DATA_W=16: group (0xFFFF, 0x0000, 0x0003, 0x0002, last) -> min1=0xFFFF (-1), max1=3. Without the macro, the same values as a valid unsigned group (0x0000, 0x0002, 0xFFFF, 0x0003) -> min1=0, max1=0xFFFF.
